// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : param_register_file
// Description : Parametrised 2-read / 1-write register file for a single-cycle
//               MIPS datapath. It offers an optional hardwired-zero register
//               and optional write-to-read bypass. After reset, a clear engine
//               zeroes every entry one per clock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK                  in   1       clock, rising edge
//   RST                  in   1       synchronous, active-high reset
//   RF_Read_Address1     in   ADDR_W  read port 1 address
//   RF_Read_Address2     in   ADDR_W  read port 2 address
//   RF_Write_Address     in   ADDR_W  write address
//   RF_Write_Data        in   DATA_W  write data
//   RF_Write_Enable_Flag in   1       write enable, sampled on CLK rise
//   RF_Data1             out  DATA_W  read port 1 data (combinational)
//   RF_Data2             out  DATA_W  read port 2 data (combinational)
//   RF_Busy              out  1       registered, high while clearing
// ============================================================================
module param_register_file #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int ZERO_REG       = 1,
    parameter int BYPASS         = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] RF_Read_Address1,
    input  logic [ADDR_W-1:0] RF_Read_Address2,
    input  logic [ADDR_W-1:0] RF_Write_Address,
    input  logic [DATA_W-1:0] RF_Write_Data,
    input  logic              RF_Write_Enable_Flag,
    output logic [DATA_W-1:0] RF_Data1,
    output logic [DATA_W-1:0] RF_Data2,
    output logic              RF_Busy
);

    localparam int              c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [ADDR_W-1:0]   r_clr_cnt_q;
    logic [ADDR_W-1:0]   w_clr_cnt_d;
    logic                r_busy_q;
    logic                w_busy_d;
    logic [DATA_W-1:0]   r_mem_q [c_DEPTH];

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_wr_commit;

    // A user write commits only in READY, outside reset, and never to the
    // hardwired-zero register. The bypass path uses the same qualifier.
    assign w_wr_commit = (r_state_q == ST_READY) && !RST && RF_Write_Enable_Flag &&
                         !((ZERO_REG != 0) && (RF_Write_Address == '0));

    always_comb begin
        w_state_d   = r_state_q;
        w_clr_cnt_d = r_clr_cnt_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = RF_Write_Address;
        w_mem_wdata = RF_Write_Data;
        if (RST) begin
            // Holding reset parks the engine at entry 0 without touching the array.
            w_clr_cnt_d = '0;
            w_state_d   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end else begin
            case (r_state_q)
                ST_CLEAR: begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = r_clr_cnt_q;
                    w_mem_wdata = '0;
                    if (r_clr_cnt_q == c_LAST) begin
                        w_state_d = ST_READY;
                    end else begin
                        w_clr_cnt_d = r_clr_cnt_q + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    w_mem_we = w_wr_commit;
                end
                default: begin
                    w_state_d = ST_READY;
                end
            endcase
        end
        w_busy_d = (w_state_d == ST_CLEAR);
    end

    always_ff @(posedge CLK) begin
        r_state_q   <= w_state_d;
        r_clr_cnt_q <= w_clr_cnt_d;
        r_busy_q    <= w_busy_d;
    end

    // The array has no reset of its own. Clearing is done through the engine
    // above, so a build with CLEAR_ON_RESET=0 leaves the contents untouched.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        if (r_busy_q) begin
            data = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
        end else if ((BYPASS != 0) && w_wr_commit && (RF_Write_Address == addr)) begin
            data = RF_Write_Data;
        end else begin
            data = r_mem_q[addr];
        end
        return data;
    endfunction

    always_comb begin
        RF_Data1 = read_port(RF_Read_Address1);
        RF_Data2 = read_port(RF_Read_Address2);
    end

    assign RF_Busy = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_register_file
// Description : Directed self-checking bench for param_register_file. It uses
//               a default build and a BYPASS=1 build, with both builds sharing
//               the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy;
    logic [31:0] b_d1;
    logic [31:0] b_d2;
    logic        b_busy;

    int total;
    int bad;
    int edges;

    param_register_file dut (
        .CLK                  (clk),
        .RST                  (rst),
        .RF_Read_Address1     (ra1),
        .RF_Read_Address2     (ra2),
        .RF_Write_Address     (wa),
        .RF_Write_Data        (wd),
        .RF_Write_Enable_Flag (we),
        .RF_Data1             (d1),
        .RF_Data2             (d2),
        .RF_Busy              (busy)
    );

    param_register_file #(.BYPASS(1)) dut_b (
        .CLK                  (clk),
        .RST                  (rst),
        .RF_Read_Address1     (ra1),
        .RF_Read_Address2     (ra2),
        .RF_Write_Address     (wa),
        .RF_Write_Data        (wd),
        .RF_Write_Enable_Flag (we),
        .RF_Data1             (b_d1),
        .RF_Data2             (b_d2),
        .RF_Busy              (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wa = a;
        wd = d;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ra1   = '0;
        ra2   = '0;
        wa    = '0;
        wd    = '0;
        we    = 1'b0;

        // Reset held for two edges.
        step();
        step();
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_busy_b", {31'd0, b_busy}, 32'd1);
        chk("reset_d1_zero", d1, 32'd0);

        // Release reset and count edges until busy falls. A write to r5
        // is issued during the clear and must be dropped.
        rst   = 1'b0;
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 4) begin
                wa = 5'd5;
                wd = 32'h1234_5678;
                we = 1'b1;
                ra1 = 5'd9;
            end
            step();
            we    = 1'b0;
            edges = i;
            if (i == 10) begin
                chk("busy_mid_clear", {31'd0, busy}, 32'd1);
                chk("busy_forces_d1", d1, 32'd0);
            end
            if (!busy) break;
        end
        chk("clear_edge_count", edges, 32'd32);
        chk("busy_b_after_clear", {31'd0, b_busy}, 32'd0);

        // Sweep both ports across every entry.
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            chk($sformatf("sweep_p1_r%0d", a), d1, 32'd0);
            chk($sformatf("sweep_p2_r%0d", 31 - a), d2, 32'd0);
        end
        ra1 = 5'd5;
        #1;
        chk("busy_write_dropped_r5", d1, 32'd0);

        // Write then read: the old value is visible before the edge, the new one after.
        wa  = 5'd10;
        wd  = 32'hAAAA_AAAA;
        we  = 1'b1;
        ra1 = 5'd10;
        ra2 = 5'd10;
        #1;
        chk("same_cycle_old_p1", d1, 32'd0);
        chk("same_cycle_old_p2", d2, 32'd0);
        chk("bypass_fwd_r10", b_d1, 32'hAAAA_AAAA);
        step();
        we = 1'b0;
        chk("after_edge_p1", d1, 32'hAAAA_AAAA);
        chk("after_edge_p2", d2, 32'hAAAA_AAAA);

        // Hardwired zero register.
        wr(5'd1, 32'h0101_0101);
        wr(5'd31, 32'h3131_3131);
        wr(5'd0, 32'hDEAD_BEEF);
        ra1 = 5'd0;
        ra2 = 5'd1;
        #1;
        chk("zero_reg_p1", d1, 32'd0);
        chk("r1_unchanged", d2, 32'h0101_0101);
        ra1 = 5'd31;
        ra2 = 5'd10;
        #1;
        chk("r31_unchanged", d1, 32'h3131_3131);
        chk("r10_unchanged", d2, 32'hAAAA_AAAA);

        // Bypass build: a matched port forwards, an unmatched port shows the old value.
        wr(5'd8, 32'h8888_8888);
        wa  = 5'd7;
        wd  = 32'h0000_00FF;
        we  = 1'b1;
        ra1 = 5'd7;
        ra2 = 5'd8;
        #1;
        chk("bypass_p1_fwd", b_d1, 32'h0000_00FF);
        chk("bypass_p2_old_r8", b_d2, 32'h8888_8888);
        chk("nobypass_p1_old_r7", d1, 32'd0);
        chk("nobypass_p2_r8", d2, 32'h8888_8888);
        step();
        we = 1'b0;
        chk("r7_after_edge", d1, 32'h0000_00FF);
        // A write to r0 is not forwarded in the bypass build.
        wa  = 5'd0;
        wd  = 32'hFFFF_FFFF;
        we  = 1'b1;
        ra1 = 5'd0;
        #1;
        chk("bypass_zero_reg", b_d1, 32'd0);
        step();
        we = 1'b0;

        // Mid-clear reset at clr_cnt == 17 restarts a full clear.
        wr(5'd3, 32'h3333_3333);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ra1 = 5'd3;
        for (int i = 0; i < 17; i++) begin
            step();
        end
        chk("busy_at_cnt17", {31'd0, busy}, 32'd1);
        chk("busy_forces_r3", d1, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("busy_after_midreset", {31'd0, busy}, 32'd1);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            edges = i;
            if (!busy) break;
        end
        chk("midreset_edge_count", edges, 32'd32);
        ra1 = 5'd3;
        ra2 = 5'd31;
        #1;
        chk("r3_cleared", d1, 32'd0);
        chk("r31_cleared", d2, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
